// File: rtl/sm83_pkg.sv
// Shared types and constants for the SM83 memory bus sequencer.
// The OAM DMA constants are only consumed when SM83_OAM_DMA_EN is defined.
package sm83_pkg;

  typedef logic [15:0] addr_t;
  typedef logic [7:0]  data_t;

  typedef enum logic [2:0] {
    IDLE,
    T1,
    T2,
    T3,
    T4
  } bus_tstate_e;

  localparam addr_t HRAM_LO  = 16'hFF80;
  localparam addr_t HRAM_HI  = 16'hFFFE;
  localparam addr_t DMA_REG  = 16'hFF46;
  localparam addr_t OAM_BASE = 16'hFE00;
  localparam int    DMA_LEN  = 160;
  localparam logic [7:0] DMA_LAST = 8'(DMA_LEN - 1);

  function automatic logic in_hram(input addr_t a);
    return (a >= HRAM_LO) && (a <= HRAM_HI);
  endfunction

endpackage

// File: rtl/sm83_oam_dma.sv
// OAM DMA engine: source page, byte index and active flag.
// Built only when SM83_OAM_DMA_EN is defined; advances one byte per grant.
`ifdef SM83_OAM_DMA_EN
module sm83_oam_dma
  import sm83_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_trig,
  input  data_t i_page,
  input  logic  i_grant,
  output logic  o_pend,
  output addr_t o_src,
  output addr_t o_dst
);

  data_t      r_page;
  logic [7:0] r_idx;
  logic       r_act;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_page <= '0;
      r_idx  <= '0;
      r_act  <= 1'b0;
    end else if (i_trig) begin
      // a new trigger always restarts from byte 0
      r_page <= i_page;
      r_idx  <= '0;
      r_act  <= 1'b1;
    end else if (i_grant && r_act) begin
      if (r_idx == DMA_LAST) begin
        r_idx <= '0;
        r_act <= 1'b0;
      end else begin
        r_idx <= r_idx + 8'd1;
      end
    end
  end

  assign o_pend = r_act;
  assign o_src  = {r_page, r_idx};
  assign o_dst  = OAM_BASE + {8'h00, r_idx};

endmodule
`endif

// File: rtl/sm83_bus_ctrl.sv
// SM83 M-cycle bus sequencer: one CPU byte access per 4-clock T1..T4 cycle.
// Define SM83_OAM_DMA_EN to build the OAM DMA engine sharing the memory ports.
module sm83_bus_ctrl
  import sm83_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_cpu_req,
  input  logic        i_cpu_we,
  input  logic [15:0] i_cpu_addr,
  input  logic [7:0]  i_cpu_wdata,
  output logic [7:0]  o_cpu_rdata,
  output logic        o_cpu_ack,
  output logic [15:0] o_mem_r_addr,
  output logic [15:0] o_mem_w_addr,
  output logic [7:0]  o_mem_w_data,
  output logic        o_mem_wen,
  input  logic [7:0]  i_mem_r_data,
  output logic        o_dma_active
);

  bus_tstate_e r_state;
  logic        r_we;
  data_t       r_wdata;
  logic        r_dma_own;
  logic        r_cpu_acc;
  logic        r_cpu_blk;

  logic  w_dma_pend;
  addr_t w_dma_src;
  addr_t w_dma_dst;
  logic  w_cpu_own;
  logic  w_dma_go;

`ifdef SM83_OAM_DMA_EN
  logic r_dma_wr;
  logic w_trig;
  logic w_grant;

  assign w_trig  = (r_state == T3) && r_dma_wr;
  assign w_grant = (r_state == T3) && r_dma_own;

  sm83_oam_dma u_dma (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_trig  (w_trig),
    .i_page  (r_wdata),
    .i_grant (w_grant),
    .o_pend  (w_dma_pend),
    .o_src   (w_dma_src),
    .o_dst   (w_dma_dst)
  );
`else
  assign w_dma_pend = 1'b0;
  assign w_dma_src  = '0;
  assign w_dma_dst  = '0;
`endif

  // HRAM stays reachable during DMA; everything else yields to it
  assign w_cpu_own = i_cpu_req && (!w_dma_pend || in_hram(i_cpu_addr));
  assign w_dma_go  = w_dma_pend && !w_cpu_own;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_we         <= 1'b0;
      r_wdata      <= '0;
      r_dma_own    <= 1'b0;
      r_cpu_acc    <= 1'b0;
      r_cpu_blk    <= 1'b0;
      o_cpu_rdata  <= '0;
      o_cpu_ack    <= 1'b0;
      o_mem_r_addr <= '0;
      o_mem_w_addr <= '0;
      o_mem_w_data <= '0;
      o_mem_wen    <= 1'b0;
      o_dma_active <= 1'b0;
`ifdef SM83_OAM_DMA_EN
      r_dma_wr     <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        IDLE, T4: begin
          o_cpu_ack    <= 1'b0;
          o_mem_wen    <= 1'b0;
          o_dma_active <= w_dma_pend;
`ifdef SM83_OAM_DMA_EN
          r_dma_wr <= i_cpu_req && i_cpu_we &&
                      (i_cpu_addr == DMA_REG);
`endif
          if (w_cpu_own) begin
            r_state      <= T1;
            r_we         <= i_cpu_we;
            r_wdata      <= i_cpu_wdata;
            o_mem_r_addr <= i_cpu_addr;
            o_mem_w_addr <= i_cpu_addr;
            r_dma_own    <= 1'b0;
            r_cpu_acc    <= 1'b1;
            r_cpu_blk    <= 1'b0;
          end else if (w_dma_go) begin
            // CPU access, if any, rides along blocked
            r_state      <= T1;
            r_we         <= i_cpu_we;
            r_wdata      <= i_cpu_wdata;
            o_mem_r_addr <= w_dma_src;
            o_mem_w_addr <= w_dma_dst;
            r_dma_own    <= 1'b1;
            r_cpu_acc    <= i_cpu_req;
            r_cpu_blk    <= 1'b1;
          end else begin
            r_state   <= IDLE;
            r_dma_own <= 1'b0;
            r_cpu_acc <= 1'b0;
            r_cpu_blk <= 1'b0;
          end
        end
        T1: r_state <= T2;
        T2: r_state <= T3;
        T3: begin
          r_state      <= T4;
          o_cpu_ack    <= r_cpu_acc;
          o_mem_wen    <= r_dma_own |
                          (r_cpu_acc & r_we & ~r_cpu_blk);
          o_mem_w_data <= r_dma_own ? i_mem_r_data : r_wdata;
          if (r_cpu_acc && !r_we) begin
            o_cpu_rdata <= r_cpu_blk ? 8'hFF : i_mem_r_data;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sm83_bus_ctrl.sv
// Self-checking bench for sm83_bus_ctrl with a behavioural memory model.
// Exercises the OAM DMA path only when SM83_OAM_DMA_EN is defined.
module tb_sm83_bus_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic [15:0] mem_r_addr;
  logic [15:0] mem_w_addr;
  logic [7:0]  mem_w_data;
  logic        mem_wen;
  logic [7:0]  mem_r_data;
  logic        dma_active;

  sm83_bus_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_cpu_req    (cpu_req),
    .i_cpu_we     (cpu_we),
    .i_cpu_addr   (cpu_addr),
    .i_cpu_wdata  (cpu_wdata),
    .o_cpu_rdata  (cpu_rdata),
    .o_cpu_ack    (cpu_ack),
    .o_mem_r_addr (mem_r_addr),
    .o_mem_w_addr (mem_w_addr),
    .o_mem_w_data (mem_w_data),
    .o_mem_wen    (mem_wen),
    .i_mem_r_data (mem_r_data),
    .o_dma_active (dma_active)
  );

  logic [7:0] mem [0:65535];
  logic [7:0] ref_mem [0:31];
  int cyc = 0;
  int wen_cnt = 0;
  int act_cnt = 0;
  int n_tests = 0;
  int n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_r_data = mem[mem_r_addr];

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (mem_wen) begin
      mem[mem_w_addr] = mem_w_data;
      wen_cnt = wen_cnt + 1;
    end
  end

  always @(negedge clk) if (dma_active === 1'b1) act_cnt = act_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Hold req until ack, drop it in the ack cycle. With scr set, the
  // request inputs are scrambled right after acceptance (DUT idle only).
  task automatic access(input logic we, input logic [15:0] a,
                        input logic [7:0] d, input bit scr,
                        output logic [7:0] rd, output int lat);
    int n0;
    bit got;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    n0 = cyc + 1;
    got = 1'b0;
    lat = -1;
    rd = 8'h00;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (scr && k == 0) begin
        cpu_we = ~we; cpu_addr = ~a; cpu_wdata = ~d;
      end
      if (cpu_ack) begin
        got = 1'b1;
        lat = cyc + 1 - n0;
        rd = cpu_rdata;
        cpu_req = 1'b0;
      end
    end
    cpu_req = 1'b0;
    if (!got) chk("ack_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp;
  } vec_t;

  vec_t vt [8];

  initial begin
    logic [7:0] rd;
    int lat, n0, acks, t1, t2, w0, bad;
    int at [3];
    logic [7:0] ad [3];

    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0000] = 8'h10;
    mem[16'h0001] = 8'h21;
    mem[16'h0002] = 8'h32;
    mem[16'h0100] = 8'h3E;
    mem[16'hFFFF] = 8'h9C;
    mem[16'hC010] = 8'h11;
    mem[16'hFF80] = 8'h77;
    mem[16'hFE00] = 8'hEE;
    mem[16'hFEA0] = 8'hEE;
    for (int i = 0; i < 160; i++) mem[16'hC100 + i] = 8'(i);
    for (int i = 0; i < 32; i++) begin
      ref_mem[i] = 8'($urandom);
      mem[16'h8000 + i] = ref_mem[i];
    end

    vt[0] = '{1'b0, 16'h0100, 8'h00, 8'h3E};
    vt[1] = '{1'b1, 16'hFFFF, 8'h5A, 8'h5A};
    vt[2] = '{1'b0, 16'hFFFF, 8'h00, 8'h5A};
    vt[3] = '{1'b1, 16'hC020, 8'h00, 8'h00};
    vt[4] = '{1'b0, 16'hC020, 8'h00, 8'h00};
    vt[5] = '{1'b1, 16'hC020, 8'hFF, 8'hFF};
    vt[6] = '{1'b0, 16'hC020, 8'h00, 8'hFF};
    vt[7] = '{1'b0, 16'h0000, 8'h00, 8'h10};

    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    cpu_addr = 16'h0; cpu_wdata = 8'h0;
    repeat (3) @(negedge clk);
    chk("rst_ack", cpu_ack, 0);
    chk("rst_wen", mem_wen, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_addr", {mem_r_addr, mem_w_addr}, 0);
    chk("rst_wdata", mem_w_data, 0);
    chk("rst_dma", dma_active, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      access(vt[i].we, vt[i].addr, vt[i].wdata, 1'b1, rd, lat);
      chk($sformatf("vec%0d_lat", i), lat, 4);
      @(negedge clk);
      chk($sformatf("vec%0d_ackpulse", i), cpu_ack, 0);
      if (vt[i].we) chk($sformatf("vec%0d_mem", i), mem[vt[i].addr], vt[i].exp);
      else chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp);
    end

    // three back-to-back reads with req held high
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0000;
    n0 = cyc + 1; acks = 0;
    for (int k = 0; k < 40 && acks < 3; k++) begin
      @(negedge clk);
      if (cpu_ack) begin
        at[acks] = cyc + 1 - n0;
        ad[acks] = cpu_rdata;
        acks++;
        cpu_addr = 16'(acks);
        if (acks == 3) cpu_req = 1'b0;
      end
    end
    cpu_req = 1'b0;
    chk("b2b_acks", acks, 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("b2b_t%0d", i), at[i], 4 * (i + 1));
      chk($sformatf("b2b_d%0d", i), ad[i], mem[i]);
    end
    @(negedge clk);

    // write then read same address, req never dropped
    w0 = wen_cnt;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'hC000; cpu_wdata = 8'hA5;
    n0 = cyc + 1; acks = 0; t1 = 0; t2 = 0; rd = 8'h00;
    for (int k = 0; k < 40 && acks < 2; k++) begin
      @(negedge clk);
      if (cpu_ack) begin
        acks++;
        if (acks == 1) begin
          t1 = cyc + 1 - n0; cpu_we = 1'b0; cpu_wdata = 8'h00;
        end else begin
          t2 = cyc + 1 - n0; rd = cpu_rdata; cpu_req = 1'b0;
        end
      end
    end
    cpu_req = 1'b0;
    @(negedge clk);
    chk("wr_rd_t1", t1, 4);
    chk("wr_rd_t2", t2, 8);
    chk("wr_rd_data", rd, 8'hA5);
    chk("wr_rd_wen_clks", wen_cnt - w0, 1);
    chk("wr_rd_mem", mem[16'hC000], 8'hA5);

    // randomized accesses against a plain array model
    for (int r = 0; r < 40; r++) begin
      int idx;
      logic w;
      logic [7:0] d;
      idx = $urandom_range(0, 31);
      w = 1'($urandom);
      d = 8'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      access(w, 16'h8000 + 16'(idx), d, 1'($urandom), rd, lat);
      chk($sformatf("rnd%0d_lat", r), lat, 4);
      if (w) ref_mem[idx] = d;
      else chk($sformatf("rnd%0d_rdata", r), rd, ref_mem[idx]);
    end
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 32; i++) if (mem[16'h8000 + i] !== ref_mem[i]) bad++;
    chk("rnd_mem_sweep", bad, 0);

    // reset in T3 of a write aborts it
    w0 = wen_cnt;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'hC010; cpu_wdata = 8'h77;
    n0 = cyc + 1;
    for (int k = 0; k < 10 && cyc != n0 + 2; k++) @(negedge clk);
    rst_n = 1'b0; cpu_req = 1'b0;
    #1;
    chk("abort_ack", cpu_ack, 0);
    chk("abort_wen", mem_wen, 0);
    chk("abort_outs", {mem_r_addr, mem_w_addr, mem_w_data, cpu_rdata}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_no_write", wen_cnt - w0, 0);
    chk("abort_mem", mem[16'hC010], 8'h11);

`ifdef SM83_OAM_DMA_EN
    access(1'b1, 16'hFF46, 8'hC1, 1'b0, rd, lat);
    act_cnt = 0;
    chk("dma_reg_lat", lat, 4);
    access(1'b0, 16'hFF80, 8'h00, 1'b0, rd, lat);
    chk("dma_hram_rd", rd, 8'h77);
    access(1'b0, 16'h0100, 8'h00, 1'b0, rd, lat);
    chk("dma_blocked_rd", rd, 8'hFF);
    for (int k = 0; k < 2000 && dma_active; k++) @(negedge clk);
    chk("dma_done", dma_active, 0);
    chk("dma_active_clks", act_cnt, 161 * 4);
    bad = 0;
    for (int i = 0; i < 160; i++) if (mem[16'hFE00 + i] !== 8'(i)) bad++;
    chk("dma_oam_copy", bad, 0);
    chk("dma_oam_last", mem[16'hFE9F], 8'h9F);
    chk("dma_oam_past", mem[16'hFEA0], 8'hEE);
    chk("dma_reg_mem", mem[16'hFF46], 8'hC1);
    chk("dma_src_intact", mem[16'h0100], 8'h3E);

    access(1'b1, 16'hFF46, 8'hC1, 1'b0, rd, lat);
    repeat (6) @(negedge clk);
    chk("dma_restart_active", dma_active, 1);
    rst_n = 1'b0;
    #1;
    chk("dma_rst_cancel", dma_active, 0);
    @(negedge clk);
    rst_n = 1'b1;
    act_cnt = 0;
    repeat (8) @(negedge clk);
    chk("dma_stays_off", act_cnt, 0);
`else
    act_cnt = 0;
    w0 = wen_cnt;
    access(1'b1, 16'hFF46, 8'hC1, 1'b0, rd, lat);
    repeat (8) @(negedge clk);
    chk("nodma_reg_mem", mem[16'hFF46], 8'hC1);
    chk("nodma_oam", mem[16'hFE00], 8'hEE);
    chk("nodma_one_write", wen_cnt - w0, 1);
    chk("nodma_active", act_cnt, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
